// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N_REQ byte streams into a uart_core over Avalon-MM (poll status, then write).
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter logic [3:0]  DATA_ADDR   = 4'h0,
    parameter logic [3:0]  STATUS_ADDR = 4'h1,
    parameter int unsigned READY_BIT   = 0
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic [3:0]           avmm_address_o,
    output logic                 avmm_read_o,
    output logic                 avmm_write_o,
    output logic [7:0]           avmm_writedata_o,
    input  logic [7:0]           avmm_readdata_i
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, POLL, CHECK, WRITE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, sel_idx;
    logic             sel_found;
    logic [7:0]       data_q;
    logic             last_q, lock_q;
    logic             accept;
    logic             status_ready;

    // Mask form keeps every status bit in the expression.
    assign status_ready = |(avmm_readdata_i & (8'h01 << READY_BIT));

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!sel_found && req_valid_i[IDX_W'(i)] && (!lock_q || idx_q == IDX_W'(i))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_start_q;
    int unsigned      k;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        k         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = 32'(rr_start_q) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!sel_found && req_valid_i[IDX_W'(k)] && (!lock_q || idx_q == IDX_W'(k))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rr_start_q <= '0;
        end else if (accept) begin
            rr_start_q <= (32'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + IDX_W'(1);
        end
    end
`endif

    assign accept = (state_q == IDLE) && sel_found;
    assign busy_o = (state_q != IDLE);

    always_comb begin
        req_ready_o = '0;
        if (arst_n_i && accept) req_ready_o[sel_idx] = 1'b1;
    end

    always_comb begin
        grant_o = '0;
        if (arst_n_i) begin
            if (state_q != IDLE || lock_q) grant_o[idx_q]   = 1'b1;
            else if (accept)               grant_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d          = state_q;
        avmm_address_o   = STATUS_ADDR;
        avmm_read_o      = 1'b0;
        avmm_write_o     = 1'b0;
        avmm_writedata_o = 8'h00;
        unique case (state_q)
            IDLE:  if (accept) state_d = POLL;
            POLL: begin
                avmm_read_o = 1'b1;
                state_d     = CHECK;
            end
            CHECK: state_d = status_ready ? WRITE : POLL;
            WRITE: begin
                avmm_write_o     = 1'b1;
                avmm_address_o   = DATA_ADDR;
                avmm_writedata_o = data_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lock is held from acceptance and released only once a last byte has been written.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q  <= sel_idx;
                data_q <= req_data_i[{sel_idx, 3'b000} +: 8];
                last_q <= req_last_i[sel_idx];
                lock_q <= 1'b1;
            end else if (state_q == WRITE) begin
                lock_q <= !last_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the status responder answers each read strobe.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  avmm_address;
    logic        avmm_read;
    logic        avmm_write;
    logic [7:0]  avmm_writedata;
    logic [7:0]  avmm_readdata = 8'h00;

    int checks = 0;
    int errors = 0;
    int polls = 0;
    int poll_base = 0;
    int busy_polls = 0;

    uart_tx_arbiter #(
        .N_REQ(4),
        .DATA_ADDR(4'h0),
        .STATUS_ADDR(4'h1),
        .READY_BIT(0)
    ) dut (
        .clk_i(clk),
        .arst_n_i(arst_n),
        .req_valid_i(req_valid),
        .req_data_i(req_data),
        .req_last_i(req_last),
        .req_ready_o(req_ready),
        .grant_o(grant),
        .busy_o(busy),
        .avmm_address_o(avmm_address),
        .avmm_read_o(avmm_read),
        .avmm_write_o(avmm_write),
        .avmm_writedata_o(avmm_writedata),
        .avmm_readdata_i(avmm_readdata)
    );

    always #5 clk = ~clk;

    // Reports "not ready" for the first busy_polls reads of a scenario, ready afterwards.
    always @(negedge clk) begin
        if (avmm_read) begin
            polls = polls + 1;
            avmm_readdata = ((polls - poll_base) > busy_polls) ? 8'h01 : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] s3_exp [5];
    logic [7:0] s4_exp [4];

    initial begin
        int n;
        int cyc;
        int sent;
        logic got;
        logic acc1;

`ifdef UART_ARB_FIXED_PRIO_EN
        s3_exp = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
        s3_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`endif
        s4_exp = '{8'h37, 8'h17, 8'h19, 8'h44};

        arst_n    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        #1;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_addr",  32'(avmm_address), 1);
        chk("rst_read",  32'(avmm_read), 0);
        chk("rst_write", 32'(avmm_write), 0);
        chk("rst_wdata", 32'(avmm_writedata), 0);
        chk("rst_grant", 32'(grant), 0);
        repeat (2) tick();
        arst_n = 1'b1;
        tick();

        // Single byte, ready on first poll
        poll_base = polls; busy_polls = 0;
        req_valid = 4'b0001; req_data[7:0] = 8'h13; req_last = 4'b0001;
        #1;
        chk("s1_ready_acc", 32'(req_ready), 32'h1);
        chk("s1_grant_acc", 32'(grant), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("s1_read",      32'(avmm_read), 1);
        chk("s1_read_addr", 32'(avmm_address), 1);
        chk("s1_busy",      32'(busy), 1);
        chk("s1_ready_off", 32'(req_ready), 0);
        chk("s1_grant",     32'(grant), 32'h1);
        tick();
        chk("s1_chk_read",  32'(avmm_read), 0);
        chk("s1_chk_write", 32'(avmm_write), 0);
        tick();
        chk("s1_write",     32'(avmm_write), 1);
        chk("s1_wr_addr",   32'(avmm_address), 0);
        chk("s1_wdata",     32'(avmm_writedata), 32'h13);
        chk("s1_no_read",   32'(avmm_read), 0);
        tick();
        chk("s1_idle_busy",  32'(busy), 0);
        chk("s1_idle_grant", 32'(grant), 0);
        chk("s1_idle_wdata", 32'(avmm_writedata), 0);
        chk("s1_idle_addr",  32'(avmm_address), 1);

        // Three not-ready polls, then ready
        poll_base = polls; busy_polls = 3;
        req_valid = 4'b0001; req_data[7:0] = 8'h22; req_last = 4'b0001;
        #1;
        chk("s2_ready_acc", 32'(req_ready), 32'h1);
        tick();
        cyc = 1; got = 1'b0;
        while (cyc < 40 && !got) begin
            chk("s2_ready_busy", 32'(req_ready), 0);
            if (avmm_write) got = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        req_valid = '0;
        chk("s2_write_seen", 32'(got), 1);
        chk("s2_latency",    32'(cyc), 9);
        chk("s2_wdata",      32'(avmm_writedata), 32'h22);
        chk("s2_reads",      32'(polls - poll_base), 4);
        tick();
        chk("s2_idle_busy",  32'(busy), 0);

        // Reset asserted while in CHECK with a ready status pending
        poll_base = polls; busy_polls = 0;
        req_valid = 4'b0010; req_data[15:8] = 8'h5A; req_last = 4'b0010;
        #1;
        chk("s5_ready_acc", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("s5_grant", 32'(grant), 32'h2);
        tick();
        chk("s5_in_check", 32'(avmm_read), 0);
        arst_n = 1'b0;
        #1;
        chk("s5_rst_busy",  32'(busy), 0);
        chk("s5_rst_grant", 32'(grant), 0);
        chk("s5_rst_write", 32'(avmm_write), 0);
        chk("s5_rst_addr",  32'(avmm_address), 1);
        chk("s5_rst_wdata", 32'(avmm_writedata), 0);
        tick();
        chk("s5_rst_hold_write", 32'(avmm_write), 0);
        arst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("s5_post_write", 32'(avmm_write), 0);
            chk("s5_post_busy",  32'(busy), 0);
        end

        // All four requesters contend; pointer must restart at 0 after reset
        poll_base = polls; busy_polls = 0;
        req_valid = 4'b1111; req_data = 32'h13121110; req_last = 4'b1111;
        #1;
        chk("s3_first_ready", 32'(req_ready), 32'h1);
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            tick();
            if (avmm_write) begin
                chk("s3_wdata", 32'(avmm_writedata), 32'(s3_exp[n]));
                n++;
            end
        end
        req_valid = '0;
        chk("s3_count", 32'(n), 5);
        tick();
        chk("s3_idle_busy", 32'(busy), 0);

        // req1 three-byte packet locks out req0
        poll_base = polls; busy_polls = 0;
        req_valid = 4'b0010; req_data[15:8] = 8'h37; req_last = 4'b0000;
        req_data[7:0] = 8'h44;
        sent = 0; n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            #1;
            acc1 = req_ready[1];
            if (n < 3) chk("s4_r0_locked", 32'(req_ready[0]), 0);
            if (sent >= 1 && n < 3) chk("s4_grant_lock", 32'(grant), 32'h2);
            tick();
            if (acc1) begin
                sent++;
                if (sent == 1) req_data[15:8] = 8'h17;
                else if (sent == 2) begin
                    req_data[15:8] = 8'h19;
                    req_last[1] = 1'b1;
                end else req_valid[1] = 1'b0;
            end
            if (sent >= 1 && n < 3) begin
                req_valid[0] = 1'b1;
                req_last[0]  = 1'b1;
            end
            if (avmm_write) begin
                chk("s4_wdata", 32'(avmm_writedata), 32'(s4_exp[n]));
                n++;
                if (n == 4) req_valid[0] = 1'b0;
            end
        end
        chk("s4_count", 32'(n), 4);
        tick();
        chk("s4_idle_busy",  32'(busy), 0);
        chk("s4_idle_grant", 32'(grant), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
